// File: rtl/tx_framer.sv
// tx_framer: wraps each AXI-Stream payload into a frame of
//   preamble | sync word | length field | payload (pad/truncate) | CRC-16 | gap
// All state advances only on beats where clk_enable is high. The O_* signals
// come from a single output register that reloads when it is empty or being
// accepted, so every state's byte appears on O_tdata one clk later.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clk_enable          beat qualifier
//   frame_en            permits starting a new frame
//   payload_length      requested payload size, sampled at frame start
//   I_tdata/tvalid/tready/tlast   payload input stream
//   O_tdata/tvalid/tready/tlast   framed output stream
//   O_tuser             1 on header bytes (preamble, sync, length)
//   pkt_sent            one-clk pulse after the frame's last byte is accepted
//   len_err             one-clk pulse on a pad or truncate event
module tx_framer #(
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          LEN_BYTES     = 2,
  parameter int          MAX_PAYLOAD   = 256,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  parameter bit          CRC_EN        = 1'b1,
  parameter int          IFG_BEATS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        frame_en,
  input  logic [15:0] payload_length,
  input  logic [7:0]  I_tdata,
  input  logic        I_tvalid,
  output logic        I_tready,
  input  logic        I_tlast,
  output logic [7:0]  O_tdata,
  output logic        O_tvalid,
  input  logic        O_tready,
  output logic        O_tlast,
  output logic        O_tuser,
  output logic        pkt_sent,
  output logic        len_err
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int HDR_W = $clog2(PREAMBLE_LEN + 1);
  localparam int GAP_W = (IFG_BEATS < 1) ? 1 : $clog2(IFG_BEATS + 1);

  localparam logic [HDR_W-1:0] PRE_LAST = HDR_W'(PREAMBLE_LEN - 1);
  localparam logic [HDR_W-1:0] LEN_LAST = HDR_W'(LEN_BYTES - 1);
  localparam logic [HDR_W-1:0] TWO_LAST = HDR_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_BEATS > 0) ? IFG_BEATS - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_PAY   = 3'd4;
  localparam logic [2:0] S_CRC   = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;
  localparam logic [2:0] S_DRAIN = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [HDR_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             trunc_q, trunc_d;
  logic             pad_q, pad_d;
  logic             drain_q, drain_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic             o_last_q, o_last_d;
  logic             o_user_q, o_user_d;
  logic             pkt_q, pkt_d;
  logic             err_q, err_d;

  logic             load, accept_out, in_rdy, in_acc;
  logic             emit, emit_user, emit_last, last_pay;
  logic [7:0]       emit_data;
  logic [15:0]      len_field;

  // CRC-16-CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  assign load       = clk_enable && (!o_valid_q || O_tready);
  assign accept_out = clk_enable && o_valid_q && O_tready;
  // Payload bytes pass straight into the output register, so input is only
  // taken on a beat where that register can load.
  assign in_rdy     = ((state_q == S_PAY) && load && !pad_q) || (state_q == S_DRAIN);
  assign in_acc     = clk_enable && I_tvalid && in_rdy;
  assign len_field  = 16'(len_q);
  assign last_pay   = (byte_cnt_q == (len_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    pad_d      = pad_q;
    drain_d    = drain_q;
    crc_d      = crc_q;
    o_data_d   = o_data_q;
    o_valid_d  = o_valid_q;
    o_last_d   = o_last_q;
    o_user_d   = o_user_q;
    pkt_d      = accept_out && o_last_q;
    err_d      = 1'b0;
    emit       = 1'b0;
    emit_data  = 8'h00;
    emit_user  = 1'b0;
    emit_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        crc_d      = 16'hFFFF;
        hdr_cnt_d  = '0;
        byte_cnt_d = '0;
        gap_cnt_d  = '0;
        pad_d      = 1'b0;
        drain_d    = 1'b0;
        if (clk_enable && frame_en && I_tvalid) begin
          if (32'(payload_length) > 32'(MAX_PAYLOAD)) begin
            len_d   = CNT_W'(MAX_PAYLOAD);
            trunc_d = 1'b1;
          end else begin
            len_d   = CNT_W'(payload_length);
            trunc_d = 1'b0;
          end
          state_d = S_PRE;
        end
      end
      S_PRE: if (load) begin
        emit      = 1'b1;
        emit_data = PREAMBLE_BYTE;
        emit_user = 1'b1;
        if (hdr_cnt_q == PRE_LAST) begin
          hdr_cnt_d = '0;
          state_d   = S_SYNC;
        end else begin
          hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
        end
      end
      S_SYNC: if (load) begin
        emit      = 1'b1;
        emit_data = (hdr_cnt_q == '0) ? SYNC_WORD[15:8] : SYNC_WORD[7:0];
        emit_user = 1'b1;
        if (hdr_cnt_q == TWO_LAST) begin
          hdr_cnt_d = '0;
          state_d   = S_LEN;
        end else begin
          hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
        end
      end
      S_LEN: if (load) begin
        emit      = 1'b1;
        emit_data = (LEN_BYTES == 2 && hdr_cnt_q == '0) ? len_field[15:8] : len_field[7:0];
        emit_user = 1'b1;
        if (hdr_cnt_q == LEN_LAST) begin
          hdr_cnt_d = '0;
          if (len_q != '0) begin
            state_d = S_PAY;
          end else if (CRC_EN) begin
            state_d = S_CRC;
          end else begin
            // Empty frame without CRC: the length field closes the frame.
            emit_last = 1'b1;
            state_d   = S_GAP;
          end
        end else begin
          hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
        end
      end
      S_PAY: if (load && (pad_q || I_tvalid)) begin
        emit       = 1'b1;
        emit_data  = pad_q ? PAD_BYTE : I_tdata;
        crc_d      = crc16_byte(crc_q, emit_data);
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (!last_pay) begin
          // Input ended early: fill the rest of the declared length.
          if (!pad_q && I_tlast) begin
            pad_d = 1'b1;
            err_d = 1'b1;
          end
        end else begin
          byte_cnt_d = '0;
          if (!pad_q && (!I_tlast || trunc_q)) err_d = 1'b1;
          // Input longer than the frame: discard the remainder after the gap.
          if (!pad_q && !I_tlast) drain_d = 1'b1;
          emit_last = !CRC_EN;
          state_d   = CRC_EN ? S_CRC : S_GAP;
        end
      end
      S_CRC: if (load) begin
        emit      = 1'b1;
        emit_data = (hdr_cnt_q == '0) ? crc_q[15:8] : crc_q[7:0];
        if (hdr_cnt_q == TWO_LAST) begin
          hdr_cnt_d = '0;
          emit_last = 1'b1;
          state_d   = S_GAP;
        end else begin
          hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
        end
      end
      S_GAP: if (clk_enable) begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = drain_q ? S_DRAIN : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_DRAIN: if (in_acc && I_tlast) begin
        drain_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      o_valid_d = emit;
      o_user_d  = emit && emit_user;
      o_last_d  = emit && emit_last;
      if (emit) o_data_d = emit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      pad_q      <= 1'b0;
      drain_q    <= 1'b0;
      crc_q      <= 16'hFFFF;
      o_data_q   <= 8'h00;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_user_q   <= 1'b0;
      pkt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      pad_q      <= pad_d;
      drain_q    <= drain_d;
      crc_q      <= crc_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
      o_user_q   <= o_user_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
    end
  end

  assign I_tready = in_rdy;
  assign O_tdata  = o_data_q;
  assign O_tvalid = o_valid_q;
  assign O_tlast  = o_last_q;
  assign O_tuser  = o_user_q;
  assign pkt_sent = pkt_q;
  assign len_err  = err_q;

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: directed sequence of frames with randomized payload bytes,
// clock-enable patterns and downstream back-pressure. Expected frames are
// built from the framing rules (header list, pad/truncate, serial CRC).
// A second instance with the CRC disabled covers the empty-frame case.
module tb_tx_framer;

  localparam int IFG    = 8;
  localparam int MAXP   = 256;
  localparam int BUDGET = 6000;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, clk_enable, frame_en, O_tready;
  logic [15:0] payload_length;
  logic [7:0]  I_tdata;
  logic        I_tvalid, I_tlast;
  logic        sel;

  logic [7:0] d0, d1;
  logic       r0, r1, v0, v1, l0, l1, u0, u1, p0, p1, e0, e1;
  logic [7:0] O_tdata;
  logic       I_tready, O_tvalid, O_tlast, O_tuser, pkt_sent, len_err;

  logic [7:0] in_q[$];
  beat_t      got[$];
  beat_t      exp_q[$];
  int         exp_err, exp_cons;

  int vectors = 0, miscompares = 0;
  int pkt_cnt, err_cnt, ce_since, cyc, ce_mode, rdy_mode;
  bit gap_chk, last_seen, prev_hold;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  tx_framer u_dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_en(frame_en && !sel),
    .payload_length(payload_length), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .I_tready(r0), .I_tlast(I_tlast), .O_tdata(d0), .O_tvalid(v0),
    .O_tready(O_tready), .O_tlast(l0), .O_tuser(u0), .pkt_sent(p0), .len_err(e0)
  );

  tx_framer #(.CRC_EN(1'b0)) u_dut_nocrc (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_en(frame_en && sel),
    .payload_length(payload_length), .I_tdata(I_tdata), .I_tvalid(I_tvalid),
    .I_tready(r1), .I_tlast(I_tlast), .O_tdata(d1), .O_tvalid(v1),
    .O_tready(O_tready), .O_tlast(l1), .O_tuser(u1), .pkt_sent(p1), .len_err(e1)
  );

  assign O_tdata  = sel ? d1 : d0;
  assign O_tvalid = sel ? v1 : v0;
  assign O_tlast  = sel ? l1 : l0;
  assign O_tuser  = sel ? u1 : u0;
  assign I_tready = sel ? r1 : r0;
  assign pkt_sent = sel ? p1 : p0;
  assign len_err  = sel ? e1 : e0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Output monitor: records accepted beats, counts pulses, checks hold
  // stability under back-pressure and the spacing between frames.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_hold = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (prev_hold) begin
        vectors++;
        assert (O_tvalid === 1'b1 && O_tdata === prev_data) else begin
          miscompares++;
          $error("FAIL hold_stable: O_tvalid=%b O_tdata=%h expected 1/%h", O_tvalid, O_tdata, prev_data);
        end
      end
      if (pkt_sent === 1'b1) pkt_cnt++;
      if (len_err === 1'b1) err_cnt++;
      if (clk_enable && O_tvalid && O_tready) begin
        if (got.size() == 0 && gap_chk && last_seen) begin
          vectors++;
          assert (ce_since >= IFG) else begin
            miscompares++;
            $error("FAIL ifg: got %0d enabled beats expected >= %0d", ce_since, IFG);
          end
        end
        b.d = O_tdata; b.u = O_tuser; b.l = O_tlast;
        got.push_back(b);
        if (O_tlast) begin
          last_seen = 1'b1;
          ce_since  = 0;
        end else begin
          ce_since++;
        end
      end else if (clk_enable) begin
        ce_since++;
      end
      prev_hold = O_tvalid && !(clk_enable && O_tready);
      prev_data = O_tdata;
    end
  end

  function automatic beat_t mk(input logic [7:0] d, input logic u);
    beat_t t;
    t.d = d; t.u = u; t.l = 1'b0;
    return t;
  endfunction

  // Reference frame built from the framing rules over in_q.
  task automatic build_model(input int plen, input bit crc_en);
    int          len, n;
    logic [15:0] lv, crc;
    logic [7:0]  b;
    logic        fb;
    beat_t       t;
    exp_q.delete();
    len = (plen > MAXP) ? MAXP : plen;
    n   = in_q.size();
    lv  = 16'(len);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'h55, 1'b1));
    exp_q.push_back(mk(8'hEB, 1'b1));
    exp_q.push_back(mk(8'h90, 1'b1));
    exp_q.push_back(mk(lv[15:8], 1'b1));
    exp_q.push_back(mk(lv[7:0], 1'b1));
    crc = 16'hFFFF;
    for (int k = 0; k < len; k++) begin
      b = (k < n) ? in_q[k] : 8'h00;
      exp_q.push_back(mk(b, 1'b0));
      for (int j = 7; j >= 0; j--) begin
        fb  = crc[15] ^ b[j];
        crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    if (crc_en) begin
      exp_q.push_back(mk(crc[15:8], 1'b0));
      exp_q.push_back(mk(crc[7:0], 1'b0));
    end
    t = exp_q.pop_back();
    t.l = 1'b1;
    exp_q.push_back(t);
    exp_err  = (len > 0 && n != len) ? 1 : 0;
    exp_cons = (len == 0) ? 0 : n;
  endtask

  // Entered and left at posedge+1.
  task automatic run_frame(input string name, input int plen, input bit crc_en, input int abort_at);
    int idx;
    bit acc, done;
    build_model(plen, crc_en);
    got.delete();
    pkt_cnt = 0; err_cnt = 0; idx = 0; done = 1'b0;
    frame_en = 1'b1;
    payload_length = 16'(plen);
    for (int k = 0; k < BUDGET; k++) begin
      case (ce_mode)
        0: clk_enable = 1'b1;
        1: clk_enable = (cyc % 32 == 0);
        default: clk_enable = 1'($urandom_range(0, 1));
      endcase
      O_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      I_tvalid = (idx < in_q.size());
      I_tdata  = (idx < in_q.size()) ? in_q[idx] : 8'h00;
      I_tlast  = (idx == in_q.size() - 1);
      @(negedge clk);
      acc = clk_enable && I_tvalid && I_tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (got.size() > 0) frame_en = 1'b0;
      if (abort_at > 0 && got.size() >= abort_at) break;
      if (got.size() >= exp_q.size() && pkt_cnt >= 1 && idx == exp_cons) begin
        done = 1'b1;
        break;
      end
    end
    I_tvalid = 1'b0;
    I_tlast  = 1'b0;
    frame_en = 1'b0;
    if (abort_at == 0) begin
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_nbytes"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i < got.size())
          chk($sformatf("%s_beat%0d_{data,user,last}", name, i), 32'(got[i]), 32'(exp_q[i]));
      end
      chk({name, "_pkt_sent"}, pkt_cnt, 1);
      chk({name, "_len_err"}, err_cnt, exp_err);
      chk({name, "_consumed"}, idx, exp_cons);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_O_tvalid"}, 32'(O_tvalid), 32'd0);
    chk({name, "_O_tdata"}, 32'(O_tdata), 32'd0);
    chk({name, "_O_tlast"}, 32'(O_tlast), 32'd0);
    chk({name, "_O_tuser"}, 32'(O_tuser), 32'd0);
    chk({name, "_I_tready"}, 32'(I_tready), 32'd0);
    chk({name, "_pkt_sent"}, 32'(pkt_sent), 32'd0);
    chk({name, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  task automatic load_ascii_digits();
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(8'(8'h31 + i));
  endtask

  task automatic load_random(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b0; frame_en = 1'b0; O_tready = 1'b0;
    payload_length = 16'd0; I_tdata = 8'h00; I_tvalid = 1'b0; I_tlast = 1'b0;
    sel = 1'b0; cyc = 0; ce_since = 0; gap_chk = 1'b0;
    ce_mode = 0; rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Reference vector "123456789", sparse clock enable.
    load_ascii_digits();
    ce_mode = 1; rdy_mode = 0; gap_chk = 1'b0;
    run_frame("ascii", 9, 1'b1, 0);
    if (got.size() >= 19) begin
      chk("ascii_crc_hi", 32'(got[17].d), 32'h29);
      chk("ascii_crc_lo", 32'(got[18].d), 32'hB1);
    end
    $display("frame ascii: %0d beats", got.size());

    // Short input: padded.
    load_random(3);
    ce_mode = 0; gap_chk = 1'b1;
    run_frame("pad", 4, 1'b1, 0);
    $display("frame pad: %0d beats", got.size());

    // Long input: truncated, remainder drained after the gap.
    load_random(5);
    run_frame("trunc", 2, 1'b1, 0);
    $display("frame trunc: %0d beats", got.size());

    load_random(6);
    run_frame("after_trunc", 6, 1'b1, 0);
    $display("frame after_trunc: %0d beats", got.size());

    // Random back-pressure.
    load_ascii_digits();
    rdy_mode = 1; gap_chk = 1'b0;
    run_frame("bp", 9, 1'b1, 0);
    $display("frame bp: %0d beats", got.size());

    // Empty payload on the CRC-less instance; the pending input stays put.
    sel = 1'b1; rdy_mode = 0;
    load_random(4);
    run_frame("empty", 0, 1'b0, 0);
    $display("frame empty: %0d beats", got.size());
    sel = 1'b0;

    // Reset in the middle of the payload.
    load_random(9);
    ce_mode = 2; rdy_mode = 1;
    run_frame("abort", 9, 1'b1, 12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    $display("frame abort: reset after %0d beats", got.size());

    load_random(9);
    ce_mode = 0; rdy_mode = 0; gap_chk = 1'b0;
    run_frame("post_reset", 9, 1'b1, 0);
    $display("frame post_reset: %0d beats", got.size());

    load_random(7);
    gap_chk = 1'b1;
    run_frame("post_reset2", 7, 1'b1, 0);
    $display("frame post_reset2: %0d beats", got.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
